// File: rtl/fetch_unit.sv
// fetch_unit -- instruction fetch stage feeding the IF/ID pipeline register.
//
// Issues one instruction-memory request at a time (req/gnt handshake, response
// on rvalid), parks a response in a one-entry skid buffer when decode is
// stalled, and handles branch/jump redirects including discarding an in-flight
// response that belongs to the abandoned path.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   is_stall[1:0]     bit1 redirect (wins), bit0 load-use stall
//   pc_branch         redirect target (low two bits ignored)
//   imem_req/addr     fetch request and address (addr stable until granted)
//   imem_gnt          request accepted this cycle
//   imem_rvalid/rdata fetch response
//   id_valid/id_pc/id_pc4/id_instr  IF/ID register contents
module fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [1:0]  is_stall,
   input  logic [31:0] pc_branch,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        id_valid,
   output logic [31:0] id_pc,
   output logic [31:0] id_pc4,
   output logic [31:0] id_instr
);

   typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

   state_t      state;
   logic [31:0] fetch_pc;    // address of the next request
   logic [31:0] req_pc;      // address of the request currently outstanding
   logic        kill;        // outstanding response belongs to a flushed path
   logic [31:0] skid_pc;
   logic [31:0] skid_instr;

   logic        redirect;
   logic        stall_lu;
   logic [31:0] target;

   assign redirect  = is_stall[1];
   assign stall_lu  = is_stall[0];
   assign target    = pc_branch & ~32'd3;
   assign imem_addr = fetch_pc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_REQ;
         imem_req   <= 1'b0;
         fetch_pc   <= RESET_PC;
         req_pc     <= RESET_PC;
         kill       <= 1'b0;
         skid_pc    <= 32'd0;
         skid_instr <= NOP_INSTR;
         id_valid   <= 1'b0;
         id_pc      <= 32'd0;
         id_pc4     <= 32'd4;
         id_instr   <= NOP_INSTR;
      end else if (redirect) begin
         // Redirect outranks the load-use stall: flush IF/ID and the skid entry.
         fetch_pc <= target;
         id_valid <= 1'b0;
         id_instr <= NOP_INSTR;
         if ((state == S_REQ && imem_req && imem_gnt) ||
             (state == S_WAIT && !imem_rvalid)) begin
            // A request already transferred and its response is still due.
            // Drain it in WAIT with kill set so only one request is ever
            // outstanding; the target request follows once it returns.
            state    <= S_WAIT;
            imem_req <= 1'b0;
            kill     <= 1'b1;
         end else begin
            // Nothing in flight (or the response lands right now and is
            // dropped): request the target on the next cycle.
            state    <= S_REQ;
            imem_req <= 1'b1;
            kill     <= 1'b0;
         end
      end else begin
         case (state)
            S_REQ: begin
               if (!stall_lu) begin
                  id_valid <= 1'b0;
                  id_instr <= NOP_INSTR;
               end
               if (imem_req && imem_gnt) begin
                  state    <= S_WAIT;
                  imem_req <= 1'b0;
                  req_pc   <= fetch_pc;
                  fetch_pc <= fetch_pc + 32'd4;
               end else begin
                  // Also raises the request on the first edge out of reset.
                  imem_req <= 1'b1;
               end
            end

            S_WAIT: begin
               if (imem_rvalid) begin
                  kill <= 1'b0;
                  if (kill) begin
                     state    <= S_REQ;
                     imem_req <= 1'b1;
                     if (!stall_lu) begin
                        id_valid <= 1'b0;
                        id_instr <= NOP_INSTR;
                     end
                  end else if (stall_lu) begin
                     state      <= S_HOLD;
                     skid_pc    <= req_pc;
                     skid_instr <= imem_rdata;
                  end else begin
                     state    <= S_REQ;
                     imem_req <= 1'b1;
                     id_valid <= 1'b1;
                     id_pc    <= req_pc;
                     id_pc4   <= req_pc + 32'd4;
                     id_instr <= imem_rdata;
                  end
               end else if (!stall_lu) begin
                  id_valid <= 1'b0;
                  id_instr <= NOP_INSTR;
               end
            end

            S_HOLD: begin
               // No new request until the parked instruction moves on.
               if (!stall_lu) begin
                  state    <= S_REQ;
                  imem_req <= 1'b1;
                  id_valid <= 1'b1;
                  id_pc    <= skid_pc;
                  id_pc4   <= skid_pc + 32'd4;
                  id_instr <= skid_instr;
               end
            end

            default: begin
               state    <= S_REQ;
               imem_req <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  is_stall = 2'b00;
   logic [31:0] pc_branch = 32'd0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt = 1'b0;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = 32'd0;
   logic        id_valid;
   logic [31:0] id_pc, id_pc4, id_instr;

   fetch_unit dut (
      .clk(clk), .rst_n(rst_n), .is_stall(is_stall), .pc_branch(pc_branch),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .id_valid(id_valid), .id_pc(id_pc), .id_pc4(id_pc4), .id_instr(id_instr)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passes = 0;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;
   exp_t sb[$];

   // Memory contents: a fixed scramble of the address.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Monitor: samples 1 time unit after each rising edge. The hazard and
   // grant inputs still hold the values the edge used.
   logic        mon_on = 1'b0;
   logic        p_req = 1'b0;
   logic [31:0] p_addr = 32'd0;
   logic        s_valid = 1'b0;
   logic [31:0] s_pc = 32'd0, s_instr = 32'd0;

   always begin
      @(posedge clk);
      #1;
      if (mon_on && rst_n) begin
         if (!id_valid) chk("bubble_instr", id_instr, NOP);
         if (is_stall == 2'b01) begin
            chk("stall_hold_valid", {31'd0, id_valid}, {31'd0, s_valid});
            chk("stall_hold_pc", id_pc, s_pc);
            chk("stall_hold_instr", id_instr, s_instr);
         end else if (id_valid) begin
            if (sb.size() == 0) begin
               chk("unexpected_delivery_pc", id_pc, 32'hxxxx_xxxx);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("id_pc", id_pc, e.pc);
               chk("id_instr", id_instr, e.instr);
               chk("id_pc4", id_pc4, e.pc + 32'd4);
            end
         end
         if (is_stall[1]) begin
            chk("redirect_valid", {31'd0, id_valid}, 32'd0);
            chk("redirect_addr", imem_addr, pc_branch & ~32'd3);
         end else if (p_req && !imem_gnt) begin
            chk("addr_stable", imem_addr, p_addr);
            chk("req_held", {31'd0, imem_req}, 32'd1);
         end
      end
      p_req   = imem_req;
      p_addr  = imem_addr;
      s_valid = id_valid;
      s_pc    = id_pc;
      s_instr = id_instr;
   end

   // Memory model state (driven only from the stimulus process).
   logic        pend = 1'b0;
   int          pend_dly = 0;
   logic [31:0] pend_data = 32'd0;

   initial begin
      int stall_cnt, gnt_hold, r;
      bit seen_wait;
      stall_cnt = 0;
      gnt_hold  = 0;

      // Reset state
      repeat (2) @(negedge clk);
      #1;
      chk("rst_req", {31'd0, imem_req}, 32'd0);
      chk("rst_addr", imem_addr, 32'd0);
      chk("rst_valid", {31'd0, id_valid}, 32'd0);
      chk("rst_pc", id_pc, 32'd0);
      chk("rst_pc4", id_pc4, 32'd4);
      chk("rst_instr", id_instr, NOP);

      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("first_req", {31'd0, imem_req}, 32'd1);
      chk("first_addr", imem_addr, 32'd0);
      chk("first_valid", {31'd0, id_valid}, 32'd0);

      // Main stream: first 16 cycles zero-wait memory without hazards, then random.
      for (int i = 0; i < 2500; i++) begin
         @(negedge clk);
         mon_on = 1'b1;
         imem_rvalid = 1'b0;
         if (pend) begin
            if (pend_dly == 0) begin
               imem_rvalid = 1'b1;
               imem_rdata  = pend_data;
               pend        = 1'b0;
            end else pend_dly--;
         end
         if (i < 16) begin
            is_stall = 2'b00;
            imem_gnt = 1'b1;
         end else begin
            r = $urandom_range(0, 99);
            if (r < 5) begin
               is_stall = 2'b10; stall_cnt = 0;
            end else if (r < 7) begin
               is_stall = 2'b11; stall_cnt = 0;
            end else if (stall_cnt > 0) begin
               is_stall = 2'b01; stall_cnt--;
            end else if (r < 20) begin
               is_stall = 2'b01; stall_cnt = $urandom_range(0, 3);
            end else is_stall = 2'b00;
            case ($urandom_range(0, 3))
               0: pc_branch = 32'h0000_0100;
               1: pc_branch = 32'h0000_0203;
               2: pc_branch = 32'hFFFF_FFF6;
               default: pc_branch = $urandom;
            endcase
            if (gnt_hold > 0) begin
               imem_gnt = 1'b0; gnt_hold--;
            end else if ($urandom_range(0, 19) == 0) begin
               imem_gnt = 1'b0; gnt_hold = 3;
            end else imem_gnt = ($urandom_range(0, 3) != 0);
         end
         // Reference: a redirect discards everything not yet in IF/ID; a
         // grant on the surviving path adds the next instruction in order.
         if (is_stall[1]) sb.delete();
         else if (imem_req && imem_gnt) sb.push_back('{imem_addr, mem_word(imem_addr)});
         if (imem_req && imem_gnt) begin
            pend      = 1'b1;
            pend_dly  = (i < 16) ? 0 : $urandom_range(0, 2);
            pend_data = mem_word(imem_addr);
         end
      end

      // Drain: no new grants, no hazards; everything granted must arrive.
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         imem_rvalid = 1'b0;
         is_stall    = 2'b00;
         imem_gnt    = 1'b0;
         if (pend) begin
            if (pend_dly == 0) begin
               imem_rvalid = 1'b1; imem_rdata = pend_data; pend = 1'b0;
            end else pend_dly--;
         end
      end
      @(negedge clk);
      imem_rvalid = 1'b0;
      chk("sb_drained", sb.size(), 32'd0);
      mon_on = 1'b0;

      // Reset pulsed while a response is outstanding.
      imem_gnt  = 1'b1;
      seen_wait = 1'b0;
      for (int i = 0; i < 10 && !seen_wait; i++) begin
         @(posedge clk);
         #1;
         if (!imem_req) seen_wait = 1'b1;
      end
      chk("reached_wait", {31'd0, seen_wait}, 32'd1);
      imem_gnt = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("midrst_req", {31'd0, imem_req}, 32'd0);
      chk("midrst_addr", imem_addr, 32'd0);
      chk("midrst_valid", {31'd0, id_valid}, 32'd0);
      chk("midrst_pc4", id_pc4, 32'd4);
      chk("midrst_instr", id_instr, NOP);
      @(negedge clk);
      rst_n = 1'b1;
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hDEAD_BEEF;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         chk("late_rvalid_valid", {31'd0, id_valid}, 32'd0);
         chk("late_rvalid_instr", id_instr, NOP);
         chk("late_rvalid_addr", imem_addr, 32'd0);
         chk("late_rvalid_req", {31'd0, imem_req}, 32'd1);
      end
      imem_rvalid = 1'b0;

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
